m_seg7_scan: RTL and testbench

Display stage directly downstream of the stopwatch. Takes the six BCD digits (min/sec/msec) and the run flag, and drives a 6-digit common-anode multiplexed 7-segment display. Includes a per-frame snapshot, an anti-ghost blanking gap, decimal-point separators and a freeze (lap) hold. Runs on the system clock, not on the 10 ms clock.

---
 rtl/m_seg7_pkg.sv | 23 ++
 rtl/m_bcd_to_seg7.sv | 11 +
 rtl/m_seg7_scan.sv | 134 +++++++++++++
 tb/tb_m_seg7_scan.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_seg7_pkg.sv
// Shared constants for the 6-digit multiplexed 7-segment scanner:
// segment patterns, digit-point positions and FSM state encoding.
package m_seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_e;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   localparam logic [2:0] DP_IDX_SEC = 3'd2;
   localparam logic [2:0] DP_IDX_MIN = 3'd4;
   localparam logic [2:0] IDX_LAST   = 3'd5;

   // Entry n is the active-low {g,f,e,d,c,b,a} pattern for nibble n; A-F show a dash.
   localparam logic [15:0][6:0] SEG_LUT = {
      SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/m_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
module m_bcd_to_seg7
   import m_seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb seg_n = SEG_LUT[bcd];

endmodule

// File: rtl/m_seg7_scan.sv
// Six-digit common-anode display scanner with per-frame snapshot, blanking gap,
// decimal points and lap freeze. Optional leading-zero blanking: define SEG7_LZB_EN.
module m_seg7_scan
   import m_seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] min,
   input  logic [7:0] sec,
   input  logic [7:0] msec,
   input  logic       run,
   input  logic       freeze,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] dig_n
);

   localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
   localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYC - 1);

   state_e      state_q, state_d;
   logic [19:0] presc_q, presc_d;
   logic [7:0]  blank_q, blank_d;
   logic [2:0]  idx_q,   idx_d;
   logic [23:0] snap_q,  snap_d;
   logic [6:0]  seg_n_q, seg_n_d;
   logic        dp_n_q,  dp_n_d;
   logic [5:0]  dig_n_q, dig_n_d;

   logic [3:0]  nibble;
   logic [6:0]  dec_seg_n;
   logic        sec_dp_on;

   // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin : scan_next
      state_d = state_q;
      presc_d = presc_q;
      blank_d = blank_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      case (state_q)
         BLANK: begin
            if (blank_q == BLANK_LAST) begin
               state_d = SHOW;
               presc_d = '0;
               if (idx_q == 3'd0 && !freeze) snap_d = {min, sec, msec};
            end else begin
               blank_d = blank_q + 8'd1;
            end
         end
         SHOW: begin
            if (presc_q == PRESC_LAST) begin
               state_d = BLANK;
               blank_d = '0;
               idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
               presc_d = presc_q + 20'd1;
            end
         end
         default: state_d = BLANK;
      endcase
   end

   // Outputs are decoded from the next-state values so the registered pins line up with the FSM state.
   always_comb begin : nibble_mux
      case (idx_d)
         3'd0:    nibble = snap_d[3:0];
         3'd1:    nibble = snap_d[7:4];
         3'd2:    nibble = snap_d[11:8];
         3'd3:    nibble = snap_d[15:12];
         3'd4:    nibble = snap_d[19:16];
         default: nibble = snap_d[23:20];
      endcase
   end

   m_bcd_to_seg7 u_dec (
      .bcd   (nibble),
      .seg_n (dec_seg_n)
   );

   // Seconds separator is lit both while running and while stopped; only lap mode removes it.
   assign sec_dp_on = (run & ~freeze) | (~run & ~freeze);

   always_comb begin : out_next
      seg_n_d = SEG_OFF;
      dp_n_d  = 1'b1;
      dig_n_d = '1;
      if (state_d == SHOW) begin
         dig_n_d = ~(6'b00_0001 << idx_d);
         seg_n_d = dec_seg_n;
         if (idx_d == DP_IDX_MIN) dp_n_d = 1'b0;
         if (idx_d == DP_IDX_SEC) dp_n_d = ~sec_dp_on;
`ifdef SEG7_LZB_EN
         if (idx_d == IDX_LAST && snap_d[23:20] == 4'h0) seg_n_d = SEG_OFF;
         if (idx_d == DP_IDX_MIN && snap_d[23:16] == 8'h00) begin
            seg_n_d = SEG_OFF;
            dp_n_d  = 1'b1;
         end
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the snapshot is reset too; its contents reach the pins and must never be X.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= BLANK;
         presc_q <= '0;
         blank_q <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         seg_n_q <= SEG_OFF;
         dp_n_q  <= 1'b1;
         dig_n_q <= '1;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         blank_q <= blank_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         seg_n_q <= seg_n_d;
         dp_n_q  <= dp_n_d;
         dig_n_q <= dig_n_d;
      end
   end

   assign seg_n = seg_n_q;
   assign dp_n  = dp_n_q;
   assign dig_n = dig_n_q;

endmodule

// File: tb/tb_m_seg7_scan.sv
// Scoreboard bench for m_seg7_scan: expected digits are queued when inputs are
// driven and popped as each lit digit is observed on the pins.
module tb_m_seg7_scan;

   localparam int SCAN_DIV  = 4;
   localparam int BLANK_CYC = 2;
   localparam int GUARD     = 200;

   typedef struct {
      logic [5:0] dig;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] min_i, sec_i, msec_i;
   logic       run, freeze;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] dig_n;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   m_seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk    (clk),
      .rst    (rst),
      .min    (min_i),
      .sec    (sec_i),
      .msec   (msec_i),
      .run    (run),
      .freeze (freeze),
      .seg_n  (seg_n),
      .dp_n   (dp_n),
      .dig_n  (dig_n)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic push_digits(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                              input logic frz, input int first);
      logic [23:0] v;
      exp_t e;
      v = {mn, sc, ms};
      for (int i = first; i < 6; i++) begin
         e.dig = ~(6'(1) << i);
         e.seg = ref_seg(v[4*i +: 4]);
         e.dp  = !((i == 4) || (i == 2 && !frz));
`ifdef SEG7_LZB_EN
         if (i == 5 && mn[7:4] == 4'h0) e.seg = 7'h7F;
         if (i == 4 && mn == 8'h00) begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
         end
`endif
         sb.push_back(e);
      end
   endtask

   // Pops n expected digits; each observed digit must match and obey lit/blank timing.
   task automatic consume(input int n, input string tag);
      exp_t       e;
      logic [5:0] d;
      logic [6:0] s;
      logic       p;
      bit         steady;
      int         lit, gap, guard;
      for (int k = 0; k < n; k++) begin
         e = sb.pop_front();
         guard = 0;
         while (dig_n !== 6'h3F && guard < GUARD) begin @(negedge clk); guard++; end
         gap = 0;
         while (dig_n === 6'h3F && guard < GUARD) begin gap++; @(negedge clk); guard++; end
         if (guard >= GUARD) begin
            n_chk++; n_fail++;
            $display("FAIL %s[%0d] timeout: no digit lit within %0d cycles", tag, k, GUARD);
            return;
         end
         d = dig_n; s = seg_n; p = dp_n;
         lit = 0; steady = 1'b1;
         while (dig_n === d && guard < GUARD) begin
            if (seg_n !== s || dp_n !== p) steady = 1'b0;
            lit++; @(negedge clk); guard++;
         end
         n_chk++;
         if (d !== e.dig) begin n_fail++; $display("FAIL %s[%0d] dig_n: got %h want %h", tag, k, d, e.dig); end
         n_chk++;
         if (s !== e.seg) begin n_fail++; $display("FAIL %s[%0d] seg_n: got %h want %h", tag, k, s, e.seg); end
         n_chk++;
         if (p !== e.dp) begin n_fail++; $display("FAIL %s[%0d] dp_n: got %b want %b", tag, k, p, e.dp); end
         n_chk++;
         if (lit != SCAN_DIV || !steady) begin
            n_fail++; $display("FAIL %s[%0d] lit: got %0d cycles steady=%0b want %0d steady=1", tag, k, lit, steady, SCAN_DIV);
         end
         n_chk++;
         if (gap != BLANK_CYC) begin n_fail++; $display("FAIL %s[%0d] blank gap: got %0d want %0d", tag, k, gap, BLANK_CYC); end
      end
   endtask

   task automatic check_pins(input string tag, input logic [5:0] wd, input logic [6:0] ws, input logic wp);
      n_chk++;
      if (dig_n !== wd) begin n_fail++; $display("FAIL %s dig_n: got %h want %h", tag, dig_n, wd); end
      n_chk++;
      if (seg_n !== ws) begin n_fail++; $display("FAIL %s seg_n: got %h want %h", tag, seg_n, ws); end
      n_chk++;
      if (dp_n !== wp) begin n_fail++; $display("FAIL %s dp_n: got %b want %b", tag, dp_n, wp); end
   endtask

   task automatic test_reset();
      rst = 1'b0; run = 1'b1; freeze = 1'b0;
      min_i = 8'h12; sec_i = 8'h34; msec_i = 8'h56;
      repeat (3) @(negedge clk);
      check_pins("reset_hold", 6'h3F, 7'h7F, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_pins("reset_rel_1", 6'h3F, 7'h7F, 1'b1);
      @(negedge clk);
      check_pins("reset_rel_2", 6'h3E, 7'h02, 1'b1);
   endtask

   task automatic test_frame_scan();
      push_digits(8'h12, 8'h34, 8'h56, 1'b0, 1);
      consume(5, "scan_f1");
      push_digits(8'h12, 8'h34, 8'h56, 1'b0, 0);
      consume(6, "scan_f2");
   endtask

   task automatic test_freeze();
      push_digits(8'h12, 8'h34, 8'h56, 1'b0, 0);
      sb.pop_back(); sb.pop_back(); sb.pop_back(); sb.pop_back(); sb.pop_back();
      consume(1, "frz_a0");
      freeze = 1'b1; sec_i = 8'h59;
      push_digits(8'h12, 8'h34, 8'h56, 1'b1, 1);
      consume(5, "frz_a");
      push_digits(8'h12, 8'h34, 8'h56, 1'b1, 0);
      consume(6, "frz_hold");
      freeze = 1'b0;
      push_digits(8'h12, 8'h59, 8'h56, 1'b0, 0);
      consume(6, "frz_release");
   endtask

   task automatic test_invalid_bcd();
      msec_i = 8'hA7;
      push_digits(8'h12, 8'h59, 8'hA7, 1'b0, 0);
      consume(6, "bad_bcd");
   endtask

   task automatic test_run_dp();
      run = 1'b0;
      push_digits(8'h12, 8'h59, 8'hA7, 1'b0, 0);
      consume(6, "stopped");
      run = 1'b1;
   endtask

   // Inputs change mid-frame to junk; the snapshot must keep the frame intact.
   task automatic test_back_to_back();
      logic [23:0] tbl [3];
      tbl[0] = 24'h89_07_18;
      tbl[1] = 24'h45_26_93;
      tbl[2] = 24'h30_41_62;
      for (int f = 0; f < 3; f++) begin
         {min_i, sec_i, msec_i} = tbl[f];
         push_digits(tbl[f][23:16], tbl[f][15:8], tbl[f][7:0], 1'b0, 0);
         consume(3, "b2b_lo");
         {min_i, sec_i, msec_i} = 24'($urandom);
         consume(3, "b2b_hi");
      end
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      while (dig_n !== 6'h37 && guard < GUARD) begin @(negedge clk); guard++; end
      n_chk++;
      if (dig_n !== 6'h37) begin n_fail++; $display("FAIL mid_reset wait: got %h want 37", dig_n); end
      rst = 1'b0;
      min_i = 8'h00; sec_i = 8'h05; msec_i = 8'h56;
      @(negedge clk);
      check_pins("mid_reset", 6'h3F, 7'h7F, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_pins("mid_rel_1", 6'h3F, 7'h7F, 1'b1);
      @(negedge clk);
      check_pins("mid_rel_2", 6'h3E, 7'h02, 1'b1);
   endtask

   task automatic test_lzb();
      push_digits(8'h00, 8'h05, 8'h56, 1'b0, 1);
      consume(5, "lzb");
   endtask

   initial begin
      rst = 1'b0; run = 1'b1; freeze = 1'b0;
      min_i = '0; sec_i = '0; msec_i = '0;
      test_reset();
      test_frame_scan();
      test_freeze();
      test_invalid_bcd();
      test_run_dp();
      test_back_to_back();
      test_mid_reset();
      test_lzb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
